// File: rtl/pc_status_unit.sv
// rtl/pc_status_unit.sv - program counter, NZCV flag register and microsequencer state
module pc_status_unit (
    input  logic        clock,
    input  logic        reset,
    input  logic [32:0] controlword,
    input  logic [63:0] constant,
    input  logic [3:0]  cond,
    input  logic [4:0]  alu_status,
    inout  wire  [63:0] databus,
    output logic [63:0] pc,
    output logic [1:0]  state,
    output logic [4:0]  status,
    output logic        branch_taken
);

    logic [63:0] pc_q, pc_d;
    logic [3:0]  flags_q, flags_d;
    logic [1:0]  state_q, state_d;

    logic        pc_bus_en;
    logic [1:0]  pc_fn;
    logic        pc_in_sel;
    logic        status_load;
    logic [1:0]  next_state;
    logic [63:0] pc_plus4;
    logic [63:0] target;
    logic        cond_true;
    logic        flag_v, flag_c, flag_n, flag_z;
    logic        unused_cw;

    assign pc_bus_en   = controlword[6];
    assign pc_fn       = controlword[5:4];
    assign pc_in_sel   = controlword[3];
    assign status_load = controlword[2];
    assign next_state  = controlword[1:0];
    assign unused_cw   = ^controlword[32:7];

    assign {flag_v, flag_c, flag_n, flag_z} = flags_q;

    assign pc_plus4 = pc_q + 64'd4;
    assign databus  = pc_bus_en ? pc_plus4 : 64'bz;

    // Conditions look only at the registered flags, so a same-cycle flag load cannot affect them.
    always_comb begin
        cond_true = 1'b1;
        case (cond)
            4'b0000: cond_true = flag_z;
            4'b0001: cond_true = !flag_z;
            4'b0010: cond_true = flag_c;
            4'b0011: cond_true = !flag_c;
            4'b0100: cond_true = flag_n;
            4'b0101: cond_true = !flag_n;
            4'b0110: cond_true = flag_v;
            4'b0111: cond_true = !flag_v;
            4'b1000: cond_true = flag_c && !flag_z;
            4'b1001: cond_true = !flag_c || flag_z;
            4'b1010: cond_true = (flag_n == flag_v);
            4'b1011: cond_true = (flag_n != flag_v);
            4'b1100: cond_true = !flag_z && (flag_n == flag_v);
            4'b1101: cond_true = flag_z || (flag_n != flag_v);
            default: cond_true = 1'b1;
        endcase
    end

    always_comb begin
        target       = pc_in_sel ? (pc_q + (constant << 2)) : {databus[63:2], 2'b00};
        pc_d         = pc_q;
        branch_taken = 1'b0;
        case (pc_fn)
            2'b00: pc_d = pc_q;
            2'b01: pc_d = pc_plus4;
            2'b10: begin
                pc_d         = target;
                branch_taken = 1'b1;
            end
            default: begin
                pc_d         = cond_true ? target : pc_plus4;
                branch_taken = cond_true;
            end
        endcase
        flags_d = status_load ? alu_status[4:1] : flags_q;
        state_d = next_state;
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            pc_q    <= 64'd0;
            flags_q <= 4'b0000;
            state_q <= 2'b00;
        end else begin
            pc_q    <= pc_d;
            flags_q <= flags_d;
            state_q <= state_d;
        end
    end

    assign pc     = pc_q;
    assign state  = state_q;
    assign status = {flags_q, alu_status[0]};

endmodule

// File: tb/tb_pc_status_unit.sv
// tb/tb_pc_status_unit.sv - scoreboard bench for pc_status_unit
module tb_pc_status_unit;

    logic        clock = 1'b0;
    logic        reset;
    logic [32:0] controlword;
    logic [63:0] constant;
    logic [3:0]  cond;
    logic [4:0]  alu_status;
    wire  [63:0] databus;
    logic [63:0] pc;
    logic [1:0]  state;
    logic [4:0]  status;
    logic        branch_taken;

    logic        tb_drv_en;
    logic [63:0] tb_drv;
    assign databus = tb_drv_en ? tb_drv : 64'bz;

    pc_status_unit dut (
        .clock(clock), .reset(reset), .controlword(controlword), .constant(constant),
        .cond(cond), .alu_status(alu_status), .databus(databus), .pc(pc),
        .state(state), .status(status), .branch_taken(branch_taken)
    );

    always #5 clock = ~clock;

    typedef struct {
        string       name;
        logic [63:0] pc;
        logic [1:0]  st;
        logic [3:0]  fl;
        logic        bt;
        logic [63:0] bus;
        logic        zl;
        logic        hand_en;
        logic [63:0] hand_pc;
        string       hand_name;
    } exp_t;

    exp_t        sb[$];
    int          checks = 0;
    int          failures = 0;

    logic [63:0] m_pc;
    logic [1:0]  m_st;
    logic [3:0]  m_fl;
    logic        hand_pend = 1'b0;
    logic [63:0] hand_val;
    string       hand_nm;

    function automatic logic model_cond(input logic [3:0] c, input logic [3:0] f);
        logic v, cy, n, z;
        {v, cy, n, z} = f;
        case (c)
            4'd0:  return z;
            4'd1:  return ~z;
            4'd2:  return cy;
            4'd3:  return ~cy;
            4'd4:  return n;
            4'd5:  return ~n;
            4'd6:  return v;
            4'd7:  return ~v;
            4'd8:  return cy & ~z;
            4'd9:  return ~cy | z;
            4'd10: return ~(n ^ v);
            4'd11: return n ^ v;
            4'd12: return ~z & ~(n ^ v);
            4'd13: return z | (n ^ v);
            default: return 1'b1;
        endcase
    endfunction

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h expected=%h", nm, act, exp);
        end
    endtask

    always @(negedge clock) begin
        if (sb.size() != 0) begin
            exp_t e;
            e = sb.pop_front();
            chk({e.name, ".pc"}, pc, e.pc);
            chk({e.name, ".state"}, {62'd0, state}, {62'd0, e.st});
            chk({e.name, ".flags"}, {60'd0, status[4:1]}, {60'd0, e.fl});
            chk({e.name, ".zlive"}, {63'd0, status[0]}, {63'd0, e.zl});
            chk({e.name, ".branch_taken"}, {63'd0, branch_taken}, {63'd0, e.bt});
            chk({e.name, ".databus"}, databus, e.bus);
            if (e.hand_en) chk({e.hand_name, ".pc_hand"}, pc, e.hand_pc);
        end
    end

    task automatic set_hand(input string nm, input logic [63:0] v);
        hand_pend = 1'b1;
        hand_val  = v;
        hand_nm   = nm;
    endtask

    // Called at posedge+1; expectations cover this cycle's combinational outputs and current registers.
    task automatic step(input logic r, input logic den, input logic [1:0] fn, input logic insel,
                        input logic sl, input logic [1:0] ns, input logic [63:0] k,
                        input logic [3:0] cc, input logic [4:0] alu, input logic ext_en,
                        input logic [63:0] ext, input string nm);
        exp_t        e;
        logic [63:0] bus_v, tgt;
        logic        ct;
        reset       = r;
        controlword = {26'h2AAAAAA, den, fn, insel, sl, ns};
        constant    = k;
        cond        = cc;
        alu_status  = alu;
        tb_drv_en   = ext_en;
        tb_drv      = ext;
        if (r) begin
            m_pc = 64'd0;
            m_st = 2'b00;
            m_fl = 4'b0000;
        end
        bus_v = den ? (m_pc + 64'd4) : (ext_en ? ext : 64'bz);
        tgt   = insel ? (m_pc + (k << 2)) : {bus_v[63:2], 2'b00};
        ct    = model_cond(cc, m_fl);
        e.name = nm; e.pc = m_pc; e.st = m_st; e.fl = m_fl; e.zl = alu[0];
        e.bt = (fn == 2'b10) || (fn == 2'b11 && ct);
        e.bus = bus_v;
        e.hand_en = hand_pend; e.hand_pc = hand_val; e.hand_name = hand_nm;
        hand_pend = 1'b0;
        sb.push_back(e);
        @(posedge clock);
        if (!r) begin
            case (fn)
                2'b00: m_pc = m_pc;
                2'b01: m_pc = m_pc + 64'd4;
                2'b10: m_pc = tgt;
                default: m_pc = ct ? tgt : m_pc + 64'd4;
            endcase
            if (sl) m_fl = alu[4:1];
            m_st = ns;
        end
        #1;
    endtask

    task automatic br(input logic [63:0] a, input logic [1:0] ns);
        step(0, 0, 2'b10, 0, 0, ns, 0, 0, 0, 1, a, "br");
    endtask

    task automatic idle(input string nm);
        step(0, 0, 2'b00, 0, 0, 2'b00, 0, 0, 0, 0, 0, nm);
    endtask

    task automatic load_flags(input logic [3:0] f);
        step(0, 0, 2'b00, 0, 1, 2'b00, 0, 0, {f, 1'b1}, 0, 0, "load_flags");
    endtask

    initial begin
        reset = 1'b1; controlword = '0; constant = '0; cond = '0; alu_status = '0;
        tb_drv_en = 1'b0; tb_drv = '0;
        m_pc = '0; m_st = '0; m_fl = '0;
        @(posedge clock); #1;
        step(1, 0, 2'b00, 0, 0, 2'b00, 0, 0, 0, 0, 0, "reset");

        step(0, 0, 2'b01, 0, 0, 2'b01, 0, 0, 0, 0, 0, "fetch0");
        step(0, 0, 2'b01, 0, 0, 2'b10, 0, 0, 0, 0, 0, "fetch1");
        step(0, 0, 2'b01, 0, 0, 2'b11, 0, 0, 0, 0, 0, "fetch2");
        step(0, 0, 2'b01, 0, 0, 2'b00, 0, 0, 0, 0, 0, "fetch3");
        set_hand("fetch_end", 64'h10);
        idle("fetch4");

        br(64'h100, 2'b00);
        step(0, 0, 2'b00, 0, 1, 2'b00, 0, 0, 5'b01010, 0, 0, "flags_zc");
        step(0, 0, 2'b11, 1, 0, 2'b01, 64'h10, 4'b0000, 0, 0, 0, "bcond_eq");
        set_hand("bcond_eq", 64'h140);
        br(64'h100, 2'b00);
        step(0, 0, 2'b11, 1, 0, 2'b01, 64'h10, 4'b0001, 0, 0, 0, "bcond_ne");
        set_hand("bcond_ne", 64'h104);
        idle("after_ne");

        br(64'h100, 2'b00);
        step(0, 0, 2'b10, 1, 0, 2'b00, 64'hFFFF_FFFF_FFFF_FFFE, 0, 0, 0, 0, "backward");
        set_hand("backward", 64'hF8);
        br(64'hFFFF_FFFF_FFFF_FFFC, 2'b00);
        step(0, 0, 2'b01, 0, 0, 2'b00, 0, 0, 0, 0, 0, "wrap");
        set_hand("wrap", 64'h0);
        br(64'h2003, 2'b00);
        set_hand("br_align", 64'h2000);
        br(64'h40, 2'b00);
        step(0, 1, 2'b00, 0, 0, 2'b00, 0, 0, 0, 0, 0, "link_on");
        idle("link_off");

        load_flags(4'b0000);
        br(64'h300, 2'b00);
        step(0, 0, 2'b11, 1, 1, 2'b00, 64'h10, 4'b0000, 5'b00010, 0, 0, "hazard");
        set_hand("hazard", 64'h304);
        idle("hazard_next");

        br(64'h500, 2'b00);
        step(0, 1, 2'b10, 0, 0, 2'b01, 0, 0, 0, 0, 0, "bus_conflict");
        set_hand("bus_conflict", 64'h504);
        idle("after_conflict");

        br(64'h80, 2'b10);
        step(1, 0, 2'b00, 0, 0, 2'b00, 0, 0, 0, 0, 0, "async_reset");
        step(0, 0, 2'b01, 0, 0, 2'b01, 0, 0, 0, 0, 0, "resume");
        set_hand("resume", 64'h4);
        idle("resume_next");

        for (int f = 0; f < 16; f++) begin
            load_flags(f[3:0]);
            for (int c = 0; c < 16; c++)
                step(0, 0, 2'b11, 1, 0, c[1:0], 64'h10, c[3:0], {4'b0000, c[0]}, 0, 0, "sweep");
        end
        idle("final");

        for (int i = 0; i < 10 && sb.size() != 0; i++) @(posedge clock);
        checks++;
        if (sb.size() != 0) begin
            failures++;
            $display("FAIL drain actual=%0d expected=0", sb.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
